// File: rtl/march_pkg.sv
// rtl/march_pkg.sv - shared FSM states and March C- element table
package march_pkg;

   typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

   localparam int NUM_ELEM = 6;
   localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

   // One bit per element, bit k = element Mk; read/write values are background bits
   localparam logic [NUM_ELEM-1:0] ELEM_UP     = 6'b100111;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_RD = 6'b111110;
   localparam logic [NUM_ELEM-1:0] ELEM_RD_VAL = 6'b010100;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_WR = 6'b011111;
   localparam logic [NUM_ELEM-1:0] ELEM_WR_VAL = 6'b001010;

   typedef struct packed {
      logic dir;
      logic has_rd;
      logic rd_val;
      logic has_wr;
      logic wr_val;
   } elem_t;

   function automatic elem_t elem_info(input logic [2:0] idx);
      elem_t e;
      e.dir    = ELEM_UP[idx];
      e.has_rd = ELEM_HAS_RD[idx];
      e.rd_val = ELEM_RD_VAL[idx];
      e.has_wr = ELEM_HAS_WR[idx];
      e.wr_val = ELEM_WR_VAL[idx];
      return e;
   endfunction

endpackage

// File: rtl/march_resp_cmp.sv
// rtl/march_resp_cmp.sv - registered read-data compare with sticky fail and first-fail capture
module march_resp_cmp #(
   parameter int AD_W   = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              vld,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [AD_W-1:0]   addr,
   input  logic [2:0]        elem,
   output logic              fail,
   output logic [AD_W-1:0]   fail_addr,
   output logic [2:0]        fail_elem
);

   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
      end else if (vld && (rdata != exp_data)) begin
         fail <= 1'b1;
         // location is kept from the first mismatch only
         if (!fail) begin
            fail_addr <= addr;
            fail_elem <= elem;
         end
      end
   end

endmodule

// File: rtl/march_c_controller.sv
// rtl/march_c_controller.sv - March C- BIST sequencer driving an address generator and dual-port RAM
module march_c_controller
   import march_pkg::*;
#(
   parameter int AD_W   = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              ag_carry,
   input  logic [AD_W-1:0]   ag_address,
   output logic              ag_reset,
   output logic              ag_preset,
   output logic              ag_en,
   output logic              ag_up_down,
   output logic              mem_re,
   output logic [AD_W-1:0]   mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_we,
   output logic [AD_W-1:0]   mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [AD_W-1:0]   fail_addr,
   output logic [2:0]        fail_elem
);

   state_t              state;
   logic [2:0]          elem;
   elem_t               cur;
   logic                cmp_clr;
   logic                cmp_vld;
   logic [AD_W-1:0]     cmp_addr;
   logic [DATA_W-1:0]   cmp_exp;
   logic [2:0]          cmp_elem;

   assign cur       = elem_info(elem);
   assign mem_raddr = ag_address;
   assign cmp_clr   = start && ((state == IDLE) || (state == DONE));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         elem       <= '0;
         ag_reset   <= 1'b1;
         ag_preset  <= 1'b0;
         ag_en      <= 1'b0;
         ag_up_down <= 1'b0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cmp_vld    <= 1'b0;
         cmp_addr   <= '0;
         cmp_exp    <= '0;
         cmp_elem   <= '0;
      end else begin
         // second half of each op pair: the address read this cycle is compared/written next cycle
         mem_we    <= (state == RUN) && cur.has_wr;
         mem_waddr <= ag_address;
         mem_wdata <= {DATA_W{cur.wr_val}};
         cmp_vld   <= (state == RUN) && cur.has_rd;
         cmp_addr  <= ag_address;
         cmp_exp   <= {DATA_W{cur.rd_val}};
         cmp_elem  <= elem;

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= SETUP;
                  elem      <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  ag_reset  <= ELEM_UP[0];
                  ag_preset <= !ELEM_UP[0];
               end
            end
            SETUP: begin
               state      <= RUN;
               ag_reset   <= 1'b0;
               ag_preset  <= 1'b0;
               ag_en      <= 1'b1;
               ag_up_down <= cur.dir;
               mem_re     <= cur.has_rd;
            end
            RUN: begin
               if (ag_carry) begin
                  state  <= DRAIN;
                  ag_en  <= 1'b0;
                  mem_re <= 1'b0;
               end
            end
            DRAIN: begin
               if (elem == LAST_ELEM) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  ag_reset <= 1'b1;
               end else begin
                  state     <= SETUP;
                  elem      <= elem + 3'd1;
                  ag_reset  <= ELEM_UP[elem + 3'd1];
                  ag_preset <= !ELEM_UP[elem + 3'd1];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   march_resp_cmp #(
      .AD_W   (AD_W),
      .DATA_W (DATA_W)
   ) u_resp_cmp (
      .clk       (clk),
      .reset     (reset),
      .clr       (cmp_clr),
      .vld       (cmp_vld),
      .rdata     (mem_rdata),
      .exp_data  (cmp_exp),
      .addr      (cmp_addr),
      .elem      (cmp_elem),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem)
   );

endmodule

// File: tb/tb_march_c_controller.sv
// tb/tb_march_c_controller.sv - randomized self-checking bench for march_c_controller
module tb_march_c_controller;

   localparam int AD_W     = 4;
   localparam int DATA_W   = 8;
   localparam int N        = 1 << AD_W;
   localparam int PER      = N + 2;
   localparam int DONE_CYC = 6 * PER + 1;
   localparam int NCYC     = 120;

   logic              clk = 1'b0;
   logic              reset, start, ag_carry;
   logic [AD_W-1:0]   ag_address;
   logic              ag_reset, ag_preset, ag_en, ag_up_down;
   logic              mem_re, mem_we, busy, done, fail;
   logic [AD_W-1:0]   mem_raddr, mem_waddr, fail_addr;
   logic [DATA_W-1:0] mem_rdata, mem_wdata;
   logic [2:0]        fail_elem;

   always #5 clk = ~clk;

   march_c_controller #(.AD_W(AD_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset), .start(start), .ag_carry(ag_carry), .ag_address(ag_address),
      .ag_reset(ag_reset), .ag_preset(ag_preset), .ag_en(ag_en), .ag_up_down(ag_up_down),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem)
   );

   // March C-: M0 up(w0) M1 up(r0,w1) M2 up(r1,w0) M3 down(r0,w1) M4 down(r1,w0) M5 up(r0)
   bit el_up [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   bit el_rd [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   bit el_rv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   bit el_wr [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   bit el_wv [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

   logic [AD_W-1:0]   gaddr = '0;
   logic [DATA_W-1:0] ram [N];
   logic [DATA_W-1:0] ram_q = '0;
   logic [DATA_W-1:0] ram_rd;
   bit                flt_on = 1'b0;
   int                flt_addr = 0;
   int                flt_bit = 0;
   bit                flt_val = 1'b0;

   always @(posedge clk) begin
      if (ag_reset)       gaddr <= '0;
      else if (ag_preset) gaddr <= '1;
      else if (ag_en)     gaddr <= ag_up_down ? gaddr + 1'b1 : gaddr - 1'b1;
      if (mem_we) ram[mem_waddr] <= mem_wdata;
      if (mem_re) ram_q <= ram_rd;
   end

   always_comb begin
      ram_rd = ram[mem_raddr];
      if (flt_on && (int'(mem_raddr) == flt_addr)) ram_rd[flt_bit] = flt_val;
   end

   assign ag_address = gaddr;
   assign ag_carry   = ag_up_down ? (gaddr == '1) : (gaddr == '0);
   assign mem_rdata  = ram_q;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tot++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Algorithm-level run of March C- over a word array with the current stuck-at fault
   task automatic model_run(output bit f, output int fa, output int fe, output int fc);
      logic [DATA_W-1:0] m [N];
      f = 1'b0; fa = 0; fe = 0; fc = 0;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) begin
            int a;
            logic [DATA_W-1:0] v;
            a = el_up[k] ? i : N - 1 - i;
            if (el_rd[k]) begin
               v = m[a];
               if (flt_on && a == flt_addr) v[flt_bit] = flt_val;
               if (v !== {DATA_W{el_rv[k]}} && !f) begin
                  f = 1'b1; fa = a; fe = k; fc = 1 + k * PER + 1 + i + 2;
               end
            end
            if (el_wr[k]) m[a] = {DATA_W{el_wv[k]}};
         end
      end
   endtask

   task automatic run_test(input string name, input bit prev_done, input bit prev_fail, input int extra_start);
      logic [127:0] e_rst, e_pre, e_en, e_ud, e_re, e_busy, e_done, e_fail;
      logic [127:0] v_rst, v_pre, v_en, v_ud, v_re, v_busy, v_done, v_fail;
      logic [31:0] ew[$], er[$], wq[$], rq[$];
      bit mf;
      int maddr, melem, mcyc, done_at;
      int wcnt [N];
      model_run(mf, maddr, melem, mcyc);
      {e_rst, e_pre, e_en, e_ud, e_re, e_busy, e_done, e_fail} = '0;
      {v_rst, v_pre, v_en, v_ud, v_re, v_busy, v_done, v_fail} = '0;
      for (int c = 0; c < NCYC; c++) begin
         int k, p;
         k = (c - 1) / PER;
         p = (c - 1) % PER;
         if (c >= 1 && c < DONE_CYC) begin
            if (p == 0) begin
               e_rst[c] = el_up[k];
               e_pre[c] = !el_up[k];
            end
            if (p >= 1 && p <= N) begin
               e_en[c] = 1'b1;
               e_ud[c] = el_up[k];
               e_re[c] = el_rd[k];
            end
            e_busy[c] = 1'b1;
         end else begin
            e_rst[c] = 1'b1;
         end
         e_done[c] = (c >= DONE_CYC) || (c == 0 && prev_done);
         e_fail[c] = (c == 0 && prev_fail) || (mf && c >= mcyc);
      end
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) begin
            int s, a;
            s = 1 + k * PER;
            a = el_up[k] ? i : N - 1 - i;
            if (el_rd[k]) er.push_back({16'(s + 1 + i), 16'(a)});
            if (el_wr[k]) ew.push_back({16'(s + 2 + i), 8'(a), {DATA_W{el_wv[k]}}});
         end
      end

      @(negedge clk);
      for (int c = 0; c < NCYC; c++) begin
         start = (c == 0) || (c == extra_start);
         v_rst[c] = ag_reset;  v_pre[c] = ag_preset; v_en[c] = ag_en; v_ud[c] = ag_up_down;
         v_re[c] = mem_re;     v_busy[c] = busy;     v_done[c] = done; v_fail[c] = fail;
         if (mem_we) wq.push_back({16'(c), 8'(mem_waddr), mem_wdata});
         if (mem_re) rq.push_back({16'(c), 16'(mem_raddr)});
         @(negedge clk);
      end
      start = 1'b0;

      check({name, ":ag_reset"}, v_rst, e_rst);
      check({name, ":ag_preset"}, v_pre, e_pre);
      check({name, ":ag_en"}, v_en, e_en);
      check({name, ":ag_up_down"}, v_ud & e_en, e_ud);
      check({name, ":mem_re"}, v_re, e_re);
      check({name, ":busy"}, v_busy, e_busy);
      check({name, ":done"}, v_done, e_done);
      check({name, ":fail"}, v_fail, e_fail);
      done_at = -1;
      for (int c = NCYC - 1; c >= 1; c--) if (v_done[c]) done_at = c;
      check({name, ":done_cycle"}, 128'(done_at), 128'(DONE_CYC));
      check({name, ":n_writes"}, 128'(wq.size()), 128'(ew.size()));
      check({name, ":n_reads"}, 128'(rq.size()), 128'(er.size()));
      for (int i = 0; i < ew.size(); i++)
         check($sformatf("%s:wr%0d{cyc,addr,data}", name, i), 128'(i < wq.size() ? wq[i] : 32'hFFFF_FFFF), 128'(ew[i]));
      for (int i = 0; i < er.size(); i++)
         check($sformatf("%s:rd%0d{cyc,addr}", name, i), 128'(i < rq.size() ? rq[i] : 32'hFFFF_FFFF), 128'(er[i]));
      for (int a = 0; a < N; a++) wcnt[a] = 0;
      foreach (wq[i]) wcnt[wq[i][15:8]]++;
      for (int a = 0; a < N; a++) check($sformatf("%s:writes_to_addr%0d", name, a), 128'(wcnt[a]), 128'(5));
      check({name, ":fail_addr"}, 128'(fail_addr), 128'(mf ? maddr : 0));
      check({name, ":fail_elem"}, 128'(fail_elem), 128'(mf ? melem : 0));
   endtask

   initial begin
      bit mf;
      int maddr, melem, mcyc;
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst:ag_reset", 128'(ag_reset), 128'(1));
      check("rst:ag_preset", 128'(ag_preset), 128'(0));
      check("rst:ag_en", 128'(ag_en), 128'(0));
      check("rst:mem_re", 128'(mem_re), 128'(0));
      check("rst:mem_we", 128'(mem_we), 128'(0));
      check("rst:mem_waddr", 128'(mem_waddr), 128'(0));
      check("rst:busy", 128'(busy), 128'(0));
      check("rst:done", 128'(done), 128'(0));
      check("rst:fail", 128'(fail), 128'(0));
      check("rst:fail_addr", 128'(fail_addr), 128'(0));
      reset = 1'b1;

      run_test("clean", 1'b0, 1'b0, $urandom_range(2, DONE_CYC - 2));

      flt_on = 1'b1; flt_addr = 5; flt_bit = 2; flt_val = 1'b0;
      run_test("sa0_a5_b2", 1'b1, 1'b0, -1);
      check("sa0_a5_b2:fail_addr_is_5", 128'(fail_addr), 128'(5));
      check("sa0_a5_b2:fail_elem_is_2", 128'(fail_elem), 128'(2));

      flt_addr = $urandom_range(0, N - 1);
      flt_bit  = $urandom_range(0, DATA_W - 1);
      flt_val  = 1'($urandom_range(0, 1));
      run_test("rand_fault", 1'b1, 1'b1, -1);

      flt_addr = $urandom_range(0, N - 1);
      flt_bit  = $urandom_range(0, DATA_W - 1);
      flt_val  = 1'b1;
      model_run(mf, maddr, melem, mcyc);
      @(negedge clk);
      for (int c = 0; c <= 40; c++) begin
         start = (c == 0);
         if (c == 40) begin
            check("abort:fail_before_reset", 128'(fail), 128'(mf && mcyc <= 40));
            reset = 1'b0;
         end
         @(negedge clk);
      end
      check("abort:ag_reset", 128'(ag_reset), 128'(1));
      check("abort:busy", 128'(busy), 128'(0));
      check("abort:mem_we", 128'(mem_we), 128'(0));
      check("abort:fail", 128'(fail), 128'(0));
      check("abort:ag_en", 128'(ag_en), 128'(0));
      reset = 1'b1;
      flt_on = 1'b0;

      run_test("after_reset", 1'b0, 1'b0, -1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
